maclaurin_odd_eval: RTL and testbench
=====================================

Name: maclaurin_odd_eval

Overview:
- Parametrised sequential evaluator of odd Maclaurin series: y = sum over k=0..N_TERMS-1 of C_k * x^(2k+1).
- Covers tanh, sin, atan, sinh and similar odd functions by swapping the coefficient LUT.
- Signed fixed-point datapath with a start/busy/done handshake, exact odd symmetry, and output saturation.
- Sits between the math-function sequencer and an external coefficient LUT, one instance per function channel.

Parameters:
- DATA_W, 18, signed width of x_in and result; two's complement, FRAC_W fractional bits.
- FRAC_W, 16, fractional bits of x, coefficients and result.
- COEF_W, 18, signed coefficient width; same FRAC_W scaling.
- N_TERMS, 8, number of series terms; legal range 1..16.
- ADDR_W, 3, coefficient address width; must satisfy 2^ADDR_W >= N_TERMS.
- GUARD_W, 4, extra accumulator MSBs; ACC_W = DATA_W + GUARD_W.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: request; sampled only in IDLE.
- x_in, in, DATA_W: signed operand; sampled only on the accepting edge.
- coef_addr, out, ADDR_W: registered LUT address.
- coef_data, in, COEF_W: signed C_k; combinational LUT response to coef_addr, sampled in the same cycle.
- busy, out, 1: high from the accepting edge until done rises.
- done, out, 1: one-cycle pulse when result is updated.
- result, out, DATA_W: signed, saturated y; held until the next done.
- ovf, out, 1: high when the current result saturated; updated with done.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, ovf=0, coef_addr=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the computation; no done is issued.
- States: IDLE -> SQ -> MAC -> FIN -> IDLE.
- IDLE:
  - With start=1, latch sign = x_in[MSB] and mag = |x_in|.
  - The most negative x_in clamps mag to 2^(DATA_W-1)-1.
  - Set coef_addr=0, busy=1, go to SQ.
  - start=0 keeps IDLE. done deasserts here.
- SQ (1 cycle):
  - xsq <= (mag*mag) >>> FRAC_W; term <= mag; acc <= 0; k <= 0.
  - Go to MAC.
- MAC (N_TERMS cycles, one per k):
  - prod = (coef_data * term) >>> FRAC_W, sign-extended to ACC_W.
  - acc <= acc + prod.
  - term <= (term*xsq) >>> FRAC_W.
  - coef_addr <= k+1; k <= k+1.
  - At k = N_TERMS-1, go to FIN; coef_addr returns to 0.
- FIN (1 cycle):
  - v = sign ? -acc : acc.
  - result <= v clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ovf <= (clamp occurred).
  - done <= 1, busy <= 0, go to IDLE.
- Latency: done is high in the cycle after the (N_TERMS+2)th rising edge following the accepting edge. Default is 10 cycles.
- Throughput: one operation per N_TERMS+3 cycles.
- start held high re-arms immediately in the IDLE cycle that follows FIN.
- start while busy=1 is ignored. x_in changes while busy do not affect the result.
- Arithmetic:
  - All products are full-precision signed; >>> truncates toward negative infinity.
  - term and xsq are kept at DATA_W+1 bits unsigned magnitude, since they are non-negative.
  - acc is ACC_W signed and never wraps within 16 terms of saturated operands.
- Odd symmetry: result(-x) = -result(x) bit-exactly, except at the clamped most-negative input.
- N_TERMS=1: result = sat(C0*x).

Test Plan:
- Zero input: tanh LUT (C = 65536, -21845, 8738, -3527, 1428, -579, 234, -95), x_in=0, start pulse -> busy for 10 cycles, done pulse, result=0, ovf=0; coef_addr steps 0..7 during MAC.
- Positive input: same LUT, x_in=32768 (0.5) -> result within ±4 LSB of 30285 (tanh 0.5), ovf=0, done exactly 10 cycles after the accepting edge.
- Negative input: x_in=-32768 -> result exactly equals the negation of the previous result. x_in=-131072 (most negative) -> treated as -131071, no X or wrap.
- Saturation: all coefficients 65536, x_in=98304 (1.5) -> result=131071, ovf=1. A following run with x_in=-98304 -> result=-131072, ovf=1.
- Handshake: start pulsed again mid-MAC with a different x_in -> ignored, and the first result is unchanged. start held high for 30 cycles -> back-to-back dones spaced 11 cycles apart.
- Reset: rst asserted in cycle 5 of an operation -> all outputs 0 immediately (asynchronous), no done. Then a fresh start completes normally.
- Minimum configuration: rebuild with N_TERMS=1, C0=65536, x_in=40000 -> result=40000, done after 3 cycles.

Source files
------------

// File: rtl/maclaurin_odd_eval.sv
// maclaurin_odd_eval
//   Sequential evaluator of an odd Maclaurin series
//      y = sum_{k=0}^{N_TERMS-1} C_k * x^(2k+1)
//   The series is evaluated on |x|, and the sign is applied once at the end,
//   so the result is bit-exactly odd. Coefficients come from an external
//   combinational LUT addressed by coef_addr.
//
//   state | meaning
//   IDLE  | wait for start, latch sign and magnitude of x_in
//   SQ    | xsq = x^2, term = |x|, clear accumulator
//   MAC   | one coefficient per cycle: acc += C_k*term, term *= xsq
//   FIN   | apply sign, saturate to DATA_W, pulse done
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start, x_in       : request and signed operand (sampled in IDLE only)
//   coef_addr         : registered coefficient address
//   coef_data         : signed coefficient C_k for coef_addr
//   busy, done        : busy from accept until done; done is a 1-cycle pulse
//   result, ovf       : saturated signed result and its saturation flag
module maclaurin_odd_eval #(
    parameter int DATA_W  = 18,
    parameter int FRAC_W  = 16,
    parameter int COEF_W  = 18,
    parameter int N_TERMS = 8,
    parameter int ADDR_W  = 3,
    parameter int GUARD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int ACC_W = DATA_W + GUARD_W;
    localparam int MAG_W = DATA_W + 1;
    localparam int K_W   = 5;
    localparam int PR_W  = COEF_W + MAG_W + 1;

    localparam logic [DATA_W-1:0]       ONE_D    = 1;
    localparam logic [DATA_W-1:0]       MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [MAG_W-1:0]        MAG_CLMP = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic [MAG_W-1:0]        MAG_MAX  = {MAG_W{1'b1}};
    localparam logic [ACC_W-1:0]        ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]        ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   SAT_MAX  = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SAT_MIN  = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [K_W-1:0]          K_LAST   = K_W'(N_TERMS - 1);
    localparam logic [K_W-1:0]          K_ONE    = 1;

    typedef enum logic [1:0] {S_IDLE, S_SQ, S_MAC, S_FIN} state_t;

    state_t                   state_q;
    logic                     sign_q;
    logic [MAG_W-1:0]         mag_q;
    logic [MAG_W-1:0]         xsq_q;
    logic [MAG_W-1:0]         term_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [K_W-1:0]           k_q;
    logic [ADDR_W-1:0]        coef_addr_q;
    logic                     busy_q;
    logic                     done_q;
    logic [DATA_W-1:0]        result_q;
    logic                     ovf_q;

    logic [DATA_W-1:0]        x_abs;
    logic [MAG_W-1:0]         mag_d;
    logic [2*MAG_W-1:0]       sq_full;
    logic [2*MAG_W-1:0]       sq_sh;
    logic [MAG_W-1:0]         xsq_d;
    logic [2*MAG_W-1:0]       tp_full;
    logic [2*MAG_W-1:0]       tp_sh;
    logic [MAG_W-1:0]         term_d;
    logic signed [PR_W-1:0]   prod_full;
    logic signed [PR_W-1:0]   prod_sh;
    logic [ACC_W-1:0]         prod_d;
    logic [ACC_W:0]           sum_d;
    logic [ACC_W-1:0]         acc_d;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    v_d;
    logic [DATA_W-1:0]        result_d;
    logic                     ovf_d;

    always_comb begin
        // |x_in|; the most negative code has no positive twin and is clamped
        x_abs = x_in[DATA_W-1] ? (~x_in + ONE_D) : x_in;
        if (x_in == MOST_NEG) begin
            mag_d = MAG_CLMP;
        end else begin
            mag_d = {1'b0, x_abs};
        end

        sq_full = mag_q * mag_q;
        sq_sh   = sq_full >> FRAC_W;
        xsq_d   = (|sq_sh[2*MAG_W-1:MAG_W]) ? MAG_MAX : sq_sh[MAG_W-1:0];

        // Odd powers of |x| > 1 outgrow MAG_W bits; they saturate instead of wrapping
        tp_full = term_q * xsq_q;
        tp_sh   = tp_full >> FRAC_W;
        term_d  = (|tp_sh[2*MAG_W-1:MAG_W]) ? MAG_MAX : tp_sh[MAG_W-1:0];

        prod_full = $signed(coef_data) * $signed({1'b0, term_q});
        prod_sh   = prod_full >>> FRAC_W;
        if (prod_sh[PR_W-1:ACC_W-1] == {(PR_W-ACC_W+1){1'b0}} ||
            prod_sh[PR_W-1:ACC_W-1] == {(PR_W-ACC_W+1){1'b1}}) begin
            prod_d = prod_sh[ACC_W-1:0];
        end else begin
            prod_d = prod_sh[PR_W-1] ? ACC_MIN : ACC_MAX;
        end

        // Saturating accumulate: large operands with saturated terms must not wrap
        sum_d = {acc_q[ACC_W-1], acc_q} + {prod_d[ACC_W-1], prod_d};
        if (sum_d[ACC_W] != sum_d[ACC_W-1]) begin
            acc_d = sum_d[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_d = sum_d[ACC_W-1:0];
        end

        acc_ext = {acc_q[ACC_W-1], acc_q};
        v_d     = sign_q ? -acc_ext : acc_ext;
        ovf_d   = 1'b0;
        if (v_d > SAT_MAX) begin
            result_d = {1'b0, {(DATA_W-1){1'b1}}};
            ovf_d    = 1'b1;
        end else if (v_d < SAT_MIN) begin
            result_d = {1'b1, {(DATA_W-1){1'b0}}};
            ovf_d    = 1'b1;
        end else begin
            result_d = v_d[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            xsq_q       <= '0;
            term_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            coef_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sign_q      <= x_in[DATA_W-1];
                        mag_q       <= mag_d;
                        coef_addr_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SQ;
                    end
                end
                S_SQ: begin
                    xsq_q   <= xsq_d;
                    term_q  <= mag_q;
                    acc_q   <= '0;
                    k_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q  <= acc_d;
                    term_q <= term_d;
                    if (k_q == K_LAST) begin
                        coef_addr_q <= '0;
                        state_q     <= S_FIN;
                    end else begin
                        coef_addr_q <= ADDR_W'(k_q + K_ONE);
                        k_q         <= k_q + K_ONE;
                    end
                end
                S_FIN: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign coef_addr = coef_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_maclaurin_odd_eval.sv
// Testbench for maclaurin_odd_eval: directed cases for tanh, saturation,
// handshake and reset, plus randomized operands and LUTs checked against
// an arithmetic reference of the series. A second instance covers N_TERMS=1.
module tb_maclaurin_odd_eval;

    localparam int N_TERMS = 8;
    localparam int LAT     = N_TERMS + 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [17:0]       x_in;
    logic [2:0]        coef_addr;
    logic [17:0]       coef_data;
    logic              busy;
    logic              done;
    logic signed [17:0] result;
    logic              ovf;

    logic              start1;
    logic [17:0]       x_in1;
    logic [0:0]        coef_addr1;
    logic [17:0]       coef_data1;
    logic              busy1;
    logic              done1;
    logic signed [17:0] result1;
    logic              ovf1;

    logic signed [17:0] lut [0:7];
    int                 addr_tr [0:40];

    int n_checks = 0;
    int n_errors = 0;

    assign coef_data  = lut[coef_addr];
    assign coef_data1 = (coef_addr1 == 1'b0) ? lut[0] : 18'd0;

    maclaurin_odd_eval dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    maclaurin_odd_eval #(.N_TERMS(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x_in(x_in1),
        .coef_addr(coef_addr1), .coef_data(coef_data1),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Series evaluated with plain integer arithmetic on |x|
    function automatic void ref_eval(input int x, input int n,
                                     output longint res, output bit ov);
        longint mag, xsq, term, acc, prod, v;
        bit neg;
        neg  = (x < 0);
        mag  = (x == -131072) ? 131071 : (neg ? -x : x);
        xsq  = (mag * mag) / 65536;
        term = mag;
        acc  = 0;
        for (int k = 0; k < n; k++) begin
            prod = (longint'(lut[k]) * term) >>> 16;
            acc  = acc + prod;
            if (acc > 2097151)  acc = 2097151;
            if (acc < -2097152) acc = -2097152;
            term = (term * xsq) / 65536;
            if (term > 524287) term = 524287;
        end
        v  = neg ? -acc : acc;
        ov = 1'b0;
        res = v;
        if (v > 131071)       begin res = 131071;  ov = 1'b1; end
        else if (v < -131072) begin res = -131072; ov = 1'b1; end
    endfunction

    task automatic run_op(input logic [17:0] x, input bit disturb,
                          output logic signed [17:0] res, output logic ov,
                          output int lat);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in  = 18'($urandom);
        check("busy_after_accept", busy, 1);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (disturb && c == 4) begin
                start = 1'b1;
                x_in  = ~x;
            end else if (disturb && c == 5) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            addr_tr[c] = coef_addr;
            if (done) lat = c;
            x_in = 18'($urandom);
        end
        res = result;
        ov  = ovf;
        if (lat >= 0) check("busy_at_done", busy, 0);
    endtask

    task automatic run_and_check(input string tag, input int x);
        logic signed [17:0] r;
        logic o;
        int l;
        longint er;
        bit eo;
        ref_eval(x, N_TERMS, er, eo);
        run_op(18'(x), 1'b0, r, o, l);
        check({tag, "_res"}, r, er);
        check({tag, "_ovf"}, o, eo);
        check({tag, "_lat"}, l, LAT);
    endtask

    initial begin
        logic signed [17:0] r, r_pos, r_ref;
        logic o;
        int l;
        longint er;
        bit eo;
        int dn_q[$];
        int dn;

        rst    = 1'b1;
        start  = 1'b0;
        x_in   = '0;
        start1 = 1'b0;
        x_in1  = '0;
        lut = '{18'sd65536, -18'sd21845, 18'sd8738, -18'sd3527,
                18'sd1428, -18'sd579, 18'sd234, -18'sd95};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_addr", coef_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // zero input with address trace
        run_op(18'd0, 1'b0, r, o, l);
        check("zero_res", r, 0);
        check("zero_ovf", o, 0);
        check("zero_lat", l, LAT);
        for (int i = 1; i <= N_TERMS; i++) check("zero_addr", addr_tr[i], i - 1);
        check("zero_addr_fin", addr_tr[N_TERMS + 1], 0);

        // tanh(0.5)
        run_and_check("pos", 32768);
        r_pos = result;
        check("pos_tanh_tol", ((r_pos >= 30281) && (r_pos <= 30289)) ? 1 : 0, 1);

        // odd symmetry
        run_op(-18'sd32768, 1'b0, r, o, l);
        check("neg_sym", r, -r_pos);
        check("neg_ovf", o, 0);
        run_op(18'sd131071, 1'b0, r_ref, o, l);
        run_and_check("mostneg", -131072);
        check("mostneg_sym", result, -r_ref);

        // mid-MAC start with a different operand, x_in churning while busy
        ref_eval(20000, N_TERMS, er, eo);
        run_op(18'd20000, 1'b1, r, o, l);
        check("disturb_res", r, er);
        check("disturb_lat", l, LAT);
        repeat (3) @(posedge clk);
        #1;
        check("disturb_idle", busy, 0);
        check("disturb_hold", result, er);

        // randomized operands with the tanh LUT, then random LUTs
        for (int i = 0; i < 25; i++) run_and_check("rnd_tanh", int'($signed(18'($urandom))));
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 8; k++) lut[k] = 18'(int'($urandom_range(0, 262143)) - 131072);
            for (int i = 0; i < 8; i++) run_and_check("rnd_lut", int'($signed(18'($urandom))));
        end

        // saturation
        for (int k = 0; k < 8; k++) lut[k] = 18'sd65536;
        run_op(18'd98304, 1'b0, r, o, l);
        check("sat_pos_res", r, 131071);
        check("sat_pos_ovf", o, 1);
        run_op(-18'sd98304, 1'b0, r, o, l);
        check("sat_neg_res", r, -131072);
        check("sat_neg_ovf", o, 1);

        // start held high: back-to-back operations
        lut = '{18'sd65536, -18'sd21845, 18'sd8738, -18'sd3527,
                18'sd1428, -18'sd579, 18'sd234, -18'sd95};
        ref_eval(10000, N_TERMS, er, eo);
        @(negedge clk);
        start = 1'b1;
        x_in  = 18'd10000;
        for (int e = 0; e <= 32; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dn_q.push_back(e);
                check("held_res", result, er);
            end
        end
        start = 1'b0;
        check("held_count", dn_q.size(), 3);
        if (dn_q.size() == 3) begin
            check("held_first", dn_q[0], LAT);
            check("held_gap1", dn_q[1] - dn_q[0], N_TERMS + 3);
            check("held_gap2", dn_q[2] - dn_q[1], N_TERMS + 3);
        end

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        x_in  = 18'd5000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_ovf", ovf, 0);
        check("arst_addr", coef_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("arst_no_done", dn, 0);
        run_and_check("after_rst", 45000);

        // N_TERMS = 1 instance
        @(negedge clk);
        start1 = 1'b1;
        x_in1  = 18'd40000;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        l = -1;
        for (int c = 1; c <= 10 && l < 0; c++) begin
            @(posedge clk);
            #1;
            if (done1) l = c;
        end
        check("min_lat", l, 3);
        check("min_res", result1, 40000);
        check("min_ovf", ovf1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
